// File: rtl/el2_lockstep_err_handler_if.sv
// Signal bundle between the lockstep checker/main core side and the error handler.
interface el2_lockstep_err_handler_if #(
  parameter int CNT_W = 8
);
  logic             corruption_detected_i;
  logic             disable_i;
  logic             clear_i;
  logic             nmi_ack_i;
  logic             err_sticky_o;
  logic [CNT_W-1:0] err_count_o;
  logic             nmi_req_o;
  logic             shadow_resync_req_o;
  logic             fatal_o;

  modport master (
    output corruption_detected_i, disable_i, clear_i, nmi_ack_i,
    input  err_sticky_o, err_count_o, nmi_req_o, shadow_resync_req_o, fatal_o
  );

  modport slave (
    input  corruption_detected_i, disable_i, clear_i, nmi_ack_i,
    output err_sticky_o, err_count_o, nmi_req_o, shadow_resync_req_o, fatal_o
  );
endinterface

// File: rtl/el2_lockstep_err_handler.sv
// DCLS mismatch responder: edge-detect, sticky/count status, NMI then shadow resync or fatal.
// Optional ALERT ack timeout enabled by defining RV_LOCKSTEP_ERR_TIMEOUT_EN.
module el2_lockstep_err_handler #(
  parameter int ERR_THRESHOLD   = 4,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int CNT_W           = 8,
  parameter int ACK_TIMEOUT     = 256
) (
  input logic                      clk,
  input logic                      rst,
  el2_lockstep_err_handler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ALERT, RESYNC, FATAL} state_t;

  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // A threshold above the counter range can never be reached by count.
  localparam bit THR_REACHABLE = (ERR_THRESHOLD <= (2**CNT_W) - 1);
  localparam logic [CNT_W-1:0] THR = THR_REACHABLE ? CNT_W'(ERR_THRESHOLD) : CNT_MAX;

  if (RST_HOLD_CYCLES < 1) begin : g_chk_hold
    $error("RST_HOLD_CYCLES must be >= 1");
  end
  if (ACK_TIMEOUT < 1) begin : g_chk_to
    $error("ACK_TIMEOUT must be >= 1");
  end
  if (!THR_REACHABLE) begin : g_chk_thr
    $warning("ERR_THRESHOLD exceeds err_count_o range; count never escalates to FATAL");
  end

  state_t             state, state_nxt;
  logic               corr_q;
  logic               blank_q, blank_nxt;
  logic               sticky, sticky_nxt;
  logic [CNT_W-1:0]   count, count_nxt, count_inc, count_acc;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic               ev, acc, at_thresh;

`ifdef RV_LOCKSTEP_ERR_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TO_W-1:0]    to_cnt, to_nxt;
`endif

  assign ev        = bus.corruption_detected_i & ~corr_q & ~bus.disable_i;
  // The first IDLE cycle after resync is blanked: shadow output is still settling.
  assign acc       = ev & (((state == IDLE) & ~blank_q) | (state == ALERT));
  assign count_inc = (count == CNT_MAX) ? count : count + 1'b1;
  assign count_acc = acc ? count_inc : count;
  assign at_thresh = THR_REACHABLE && (count_acc >= THR);

  always_comb begin
    state_nxt  = state;
    count_nxt  = count_acc;
    sticky_nxt = sticky | acc;
    hold_nxt   = '0;
    blank_nxt  = 1'b0;
`ifdef RV_LOCKSTEP_ERR_TIMEOUT_EN
    to_nxt     = (state == ALERT) ? to_cnt + 1'b1 : '0;
`endif
    case (state)
      IDLE: begin
        if (acc) begin
          state_nxt = ALERT;
          if (bus.clear_i) count_nxt = CNT_W'(1);
        end else if (bus.clear_i) begin
          count_nxt  = '0;
          sticky_nxt = 1'b0;
        end
      end
      ALERT: begin
        if (bus.nmi_ack_i) state_nxt = at_thresh ? FATAL : RESYNC;
`ifdef RV_LOCKSTEP_ERR_TIMEOUT_EN
        else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) state_nxt = FATAL;
`endif
      end
      RESYNC: begin
        if (hold_cnt == HOLD_W'(RST_HOLD_CYCLES - 1)) begin
          state_nxt = IDLE;
          blank_nxt = 1'b1;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      FATAL: ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      corr_q   <= 1'b0;
      blank_q  <= 1'b0;
      sticky   <= 1'b0;
      count    <= '0;
      hold_cnt <= '0;
`ifdef RV_LOCKSTEP_ERR_TIMEOUT_EN
      to_cnt   <= '0;
`endif
    end else begin
      state    <= state_nxt;
      corr_q   <= bus.corruption_detected_i;
      blank_q  <= blank_nxt;
      sticky   <= sticky_nxt;
      count    <= count_nxt;
      hold_cnt <= hold_nxt;
`ifdef RV_LOCKSTEP_ERR_TIMEOUT_EN
      to_cnt   <= to_nxt;
`endif
    end
  end

  assign bus.err_sticky_o        = sticky;
  assign bus.err_count_o         = count;
  assign bus.nmi_req_o           = (state == ALERT);
  assign bus.shadow_resync_req_o = (state == RESYNC);
  assign bus.fatal_o             = (state == FATAL);

endmodule

// File: tb/tb_el2_lockstep_err_handler.sv
// Scoreboard bench: stimulus pushes cycle-stamped expectations, a negedge monitor pops and compares.
module tb_el2_lockstep_err_handler;
  localparam int HOLD = 16;
  localparam int TO   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  el2_lockstep_err_handler_if #(.CNT_W(8)) b0 ();
  el2_lockstep_err_handler_if #(.CNT_W(2)) b1 ();

  el2_lockstep_err_handler #(.ERR_THRESHOLD(4), .RST_HOLD_CYCLES(HOLD), .CNT_W(8), .ACK_TIMEOUT(TO))
    dut0 (.clk(clk), .rst(rst), .bus(b0));
  el2_lockstep_err_handler #(.ERR_THRESHOLD(3), .RST_HOLD_CYCLES(2), .CNT_W(2), .ACK_TIMEOUT(TO))
    dut1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct {
    int           cyc;
    bit           u;
    logic [95:0]  tag;
    int           cnt;
    bit           st, nmi, sh, fat;
  } exp_t;

  exp_t sb[$];
  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int d, input bit u, input logic [95:0] tag, input int cnt,
                           input bit st, input bit nmi, input bit sh, input bit fat);
    exp_t e;
    e.cyc = cyc + d; e.u = u; e.tag = tag; e.cnt = cnt;
    e.st = st; e.nmi = nmi; e.sh = sh; e.fat = fat;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    int   acnt;
    logic ast, anmi, ash, afat;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        if (sb[i].u) begin
          acnt = int'(b1.err_count_o); ast = b1.err_sticky_o; anmi = b1.nmi_req_o;
          ash = b1.shadow_resync_req_o; afat = b1.fatal_o;
        end else begin
          acnt = int'(b0.err_count_o); ast = b0.err_sticky_o; anmi = b0.nmi_req_o;
          ash = b0.shadow_resync_req_o; afat = b0.fatal_o;
        end
        checks++;
        if (sb[i].cyc != cyc || acnt != sb[i].cnt || ast !== sb[i].st || anmi !== sb[i].nmi ||
            ash !== sb[i].sh || afat !== sb[i].fat) begin
          errors++;
          $display("FAIL %0s u%0d cyc=%0d/%0d got cnt=%0d st=%b nmi=%b sh=%b fat=%b want cnt=%0d st=%b nmi=%b sh=%b fat=%b",
                   sb[i].tag, sb[i].u, cyc, sb[i].cyc, acnt, ast, anmi, ash, afat,
                   sb[i].cnt, sb[i].st, sb[i].nmi, sb[i].sh, sb[i].fat);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    b0.corruption_detected_i = 0; b0.disable_i = 0; b0.clear_i = 0; b0.nmi_ack_i = 0;
    b1.corruption_detected_i = 0; b1.disable_i = 0; b1.clear_i = 0; b1.nmi_ack_i = 0;
    rst = 1;
    step(2);
    expect_at(0, 0, "reset", 0, 0, 0, 0, 0);
    expect_at(0, 1, "reset", 0, 0, 0, 0, 0);
    rst = 0;
    step(1);

    // T1: long level -> single event
    b0.corruption_detected_i = 1;
    expect_at(1, 0, "t1_edge", 1, 1, 1, 0, 0);
    step(10);
    expect_at(0, 0, "t1_hold", 1, 1, 1, 0, 0);
    b0.corruption_detected_i = 0;
    step(2);
    b0.nmi_ack_i = 1;
    expect_at(1, 0, "t1_ack", 1, 1, 0, 1, 0);
    step(1);
    b0.nmi_ack_i = 0;
    step(HOLD + 1);
    b0.clear_i = 1;
    expect_at(1, 0, "t1_clear", 0, 0, 0, 0, 0);
    step(1);
    b0.clear_i = 0;

    // T2: resync hold length, edge during RESYNC and in the blank cycle
    b0.corruption_detected_i = 1;
    expect_at(1, 0, "t2_nmi", 1, 1, 1, 0, 0);
    step(1);
    b0.corruption_detected_i = 0;
    step(3);
    b0.nmi_ack_i = 1;
    expect_at(0, 0, "t2_preack", 1, 1, 1, 0, 0);
    step(1);
    b0.nmi_ack_i = 0;
    for (int k = 0; k < HOLD; k++) expect_at(k, 0, "t2_rs", 1, 1, 0, 1, 0);
    expect_at(HOLD, 0, "t2_idle", 1, 1, 0, 0, 0);
    step(3);
    b0.corruption_detected_i = 1;
    step(1);
    b0.corruption_detected_i = 0;
    step(HOLD - 4);
    b0.corruption_detected_i = 1;
    expect_at(1, 0, "t2_blank", 1, 1, 0, 0, 0);
    step(1);
    b0.corruption_detected_i = 0;
    b0.clear_i = 1;
    expect_at(1, 0, "t2_clear", 0, 0, 0, 0, 0);
    step(1);
    b0.clear_i = 0;

    // T3: four rounds, fourth escalates to FATAL
    for (int r = 1; r <= 4; r++) begin
      b0.corruption_detected_i = 1;
      expect_at(1, 0, "t3_alert", r, 1, 1, 0, 0);
      step(1);
      b0.corruption_detected_i = 0;
      step(2);
      b0.nmi_ack_i = 1;
      step(1);
      b0.nmi_ack_i = 0;
      if (r < 4) begin
        expect_at(0, 0, "t3_resync", r, 1, 0, 1, 0);
        step(HOLD + 1);
      end else begin
        expect_at(0, 0, "t3_fatal", 4, 1, 0, 0, 1);
      end
    end
    b0.clear_i = 1; b0.corruption_detected_i = 1; b0.nmi_ack_i = 1;
    expect_at(2, 0, "t3_absorb", 4, 1, 0, 0, 1);
    step(1);
    b0.clear_i = 0; b0.corruption_detected_i = 0; b0.nmi_ack_i = 0;
    step(3);
    expect_at(0, 0, "t3_persist", 4, 1, 0, 0, 1);
    rst = 1;
    step(1);
    rst = 0;
    expect_at(0, 0, "t3_rst", 0, 0, 0, 0, 0);
    step(1);

    // T4: disabled edges, then clear+edge in IDLE, then clear in ALERT
    b0.disable_i = 1;
    repeat (3) begin
      b0.corruption_detected_i = 1;
      step(1);
      b0.corruption_detected_i = 0;
      step(1);
    end
    b0.disable_i = 0;
    expect_at(1, 0, "t4_dis", 0, 0, 0, 0, 0);
    step(1);
    b0.clear_i = 1; b0.corruption_detected_i = 1;
    expect_at(1, 0, "t4_clr_ev", 1, 1, 1, 0, 0);
    step(1);
    b0.corruption_detected_i = 0;
    expect_at(1, 0, "t4_clr_alert", 1, 1, 1, 0, 0);
    step(1);
    b0.clear_i = 0;

    // T5: events in ALERT, same-cycle ev+ack hits threshold
    b0.corruption_detected_i = 1;
    expect_at(1, 0, "t5_ev2", 2, 1, 1, 0, 0);
    step(1);
    b0.corruption_detected_i = 0;
    step(1);
    b0.corruption_detected_i = 1;
    expect_at(1, 0, "t5_ev3", 3, 1, 1, 0, 0);
    step(1);
    b0.corruption_detected_i = 0;
    step(1);
    b0.corruption_detected_i = 1; b0.nmi_ack_i = 1;
    expect_at(1, 0, "t5_sameack", 4, 1, 0, 0, 1);
    step(1);
    b0.corruption_detected_i = 0; b0.nmi_ack_i = 0;
    rst = 1;
    step(1);
    rst = 0;
    b0.nmi_ack_i = 1;
    expect_at(1, 0, "t5_ack_idle", 0, 0, 0, 0, 0);
    step(1);
    b0.nmi_ack_i = 0;

    // Saturation on the 2-bit instance (threshold 3)
    for (int k = 1; k <= 5; k++) begin
      b1.corruption_detected_i = 1;
      expect_at(1, 1, "sat", (k > 3) ? 3 : k, 1, 1, 0, 0);
      step(1);
      b1.corruption_detected_i = 0;
      step(1);
    end
    b1.nmi_ack_i = 1;
    expect_at(1, 1, "sat_fatal", 3, 1, 0, 0, 1);
    step(1);
    b1.nmi_ack_i = 0;
    rst = 1;
    step(1);
    rst = 0;
    step(1);

    // T6: ack timeout behaviour
`ifdef RV_LOCKSTEP_ERR_TIMEOUT_EN
    b0.corruption_detected_i = 1;
    step(1);
    b0.corruption_detected_i = 0;
    expect_at(TO - 1, 0, "t6_lastalert", 1, 1, 1, 0, 0);
    expect_at(TO, 0, "t6_to_fatal", 1, 1, 0, 0, 1);
    step(TO + 2);
    rst = 1;
    step(1);
    rst = 0;
    step(1);
    b0.corruption_detected_i = 1;
    step(1);
    b0.corruption_detected_i = 0;
    step(TO - 1);
    b0.nmi_ack_i = 1;
    expect_at(1, 0, "t6_ack_win", 1, 1, 0, 1, 0);
    step(1);
    b0.nmi_ack_i = 0;
    step(HOLD + 1);
`else
    b0.corruption_detected_i = 1;
    step(1);
    b0.corruption_detected_i = 0;
    step(1000);
    expect_at(0, 0, "t6_no_to", 1, 1, 1, 0, 0);
    b0.nmi_ack_i = 1;
    expect_at(1, 0, "t6_ack", 1, 1, 0, 1, 0);
    step(1);
    b0.nmi_ack_i = 0;
    step(HOLD + 1);
`endif

    step(3);
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain pending=%0d want 0", sb.size());
      errors += sb.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
